// File: rtl/aes_padding_adder_if.sv
// rtl/aes_padding_adder_if.sv - upstream/downstream word stream bundle for aes_padding_adder
interface aes_padding_adder_if #(
    parameter int WORD_SIZE = 32
);
    logic [WORD_SIZE-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/aes_padding_adder.sv
// rtl/aes_padding_adder.sv - forwards a message then appends word-granular pad words to the block boundary
// Optional AES_PAD_FULL_BLOCK_EN: block-aligned messages (including empty ones) get a full pad block.
module aes_padding_adder #(
    parameter int WORD_SIZE         = 32,
    parameter int BLOCK_WORDS       = 4,
    parameter int WORD_COUNTER_SIZE = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         msg_start,
    input  logic [WORD_COUNTER_SIZE-1:0] msg_words_out,
    aes_padding_adder_if.slave           s,
    output logic [WORD_COUNTER_SIZE-1:0] msg_words_in_adder,
    output logic                         busy,
    output logic                         msg_done
);
    localparam int LOG2B = $clog2(BLOCK_WORDS);
    localparam int PW    = LOG2B + 1;

    typedef enum logic [1:0] {IDLE, PASS, PAD} state_t;

    state_t                       state_q;
    logic [WORD_COUNTER_SIZE-1:0] len_q;
    logic [WORD_COUNTER_SIZE-1:0] cnt_q;
    logic [WORD_COUNTER_SIZE-1:0] cnt_d;
    logic [PW-1:0]                pad_q;
    logic [PW-1:0]                pad_left_q;
    logic [PW-1:0]                pad_d;
    logic [PW-1:0]                pad_full;
    logic [WORD_SIZE-1:0]         out_data_q;
    logic                         out_valid_q;
    logic                         out_last_q;
    logic                         done_q;
    logic                         in_ready_w;
    logic                         slot_free;
    logic                         in_fire;
    logic                         out_fire;
    logic                         last_data;

    always_comb begin
        pad_full = PW'(BLOCK_WORDS) - PW'(msg_words_out[LOG2B-1:0]);
`ifdef AES_PAD_FULL_BLOCK_EN
        pad_d = pad_full;
`else
        pad_d = (msg_words_out[LOG2B-1:0] == '0) ? '0 : pad_full;
`endif
    end

    // The output slot can be refilled in the same cycle the held word leaves.
    assign slot_free  = !out_valid_q || s.out_ready;
    assign in_ready_w = (state_q == PASS) && slot_free;
    assign in_fire    = s.in_valid && in_ready_w;
    assign out_fire   = out_valid_q && s.out_ready;
    assign cnt_d      = cnt_q + WORD_COUNTER_SIZE'(1);
    assign last_data  = (cnt_d == len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            pad_q       <= '0;
            pad_left_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= out_fire && out_last_q;
            if (out_fire) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    // In IDLE the slot can only hold the previous message's last word.
                    if (msg_start && !out_valid_q) begin
                        len_q      <= msg_words_out;
                        pad_q      <= pad_d;
                        pad_left_q <= pad_d;
                        cnt_q      <= '0;
                        if (msg_words_out != '0) begin
                            state_q <= PASS;
                        end else if (pad_d != '0) begin
                            state_q <= PAD;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                PASS: begin
                    if (in_fire) begin
                        out_data_q  <= s.in_data;
                        out_valid_q <= 1'b1;
                        out_last_q  <= last_data && (pad_q == '0);
                        cnt_q       <= cnt_d;
                        if (last_data) begin
                            state_q <= (pad_q == '0) ? IDLE : PAD;
                        end
                    end
                end
                PAD: begin
                    if (slot_free) begin
                        out_data_q  <= WORD_SIZE'(pad_q);
                        out_valid_q <= 1'b1;
                        out_last_q  <= (pad_left_q == PW'(1));
                        pad_left_q  <= pad_left_q - PW'(1);
                        if (pad_left_q == PW'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s.in_ready          = in_ready_w;
    assign s.out_data          = out_data_q;
    assign s.out_valid         = out_valid_q;
    assign s.out_last          = out_last_q;
    assign msg_words_in_adder  = cnt_q;
    assign busy                = (state_q != IDLE);
    assign msg_done            = done_q;
endmodule

// File: tb/tb_aes_padding_adder.sv
// tb/tb_aes_padding_adder.sv - randomized bench for aes_padding_adder against a queue-based padding model
module tb_aes_padding_adder;
    localparam int WS  = 32;
    localparam int BW  = 4;
    localparam int WCS = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           msg_start;
    logic [WCS-1:0] msg_words_out;
    logic [WCS-1:0] msg_words_in_adder;
    logic           busy;
    logic           msg_done;

    aes_padding_adder_if #(.WORD_SIZE(WS)) bus();

    aes_padding_adder #(
        .WORD_SIZE(WS),
        .BLOCK_WORDS(BW),
        .WORD_COUNTER_SIZE(WCS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .msg_start(msg_start),
        .msg_words_out(msg_words_out),
        .s(bus.slave),
        .msg_words_in_adder(msg_words_in_adder),
        .busy(busy),
        .msg_done(msg_done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] src_q[$];
    logic [31:0] exp_q[$];
    bit          exp_last_q[$];
    logic [31:0] got_q[$];
    bit          drv_en = 1'b0;
    int          valid_pct = 100;
    int          ready_pct = 100;
    bit          ready_pat_en = 1'b0;
    logic [3:0]  ready_pat = 4'b1001;
    int          pat_idx = 0;
    bit          in_hs_prev = 1'b0;
    bit          exp_done_now = 1'b0;
    bit          start_zero_flag = 1'b0;
    bit          rst_prev = 1'b1;
    bit          stall_prev = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    int          in_acc = 0;
    logic [31:0] e_word;
    bit          e_last;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Stream driver: random valid/ready, pops the source word once it was accepted.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (drv_en) begin
                if (in_hs_prev && src_q.size() > 0) void'(src_q.pop_front());
                if (src_q.size() > 0 && $urandom_range(99) < valid_pct) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = src_q[0];
                end else begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = $urandom;
                end
                if (ready_pat_en) begin
                    bus.out_ready = ready_pat[pat_idx % 4];
                    pat_idx++;
                end else begin
                    bus.out_ready = ($urandom_range(99) < ready_pct);
                end
            end
        end
    end

    // Compare process: every cycle away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            in_hs_prev   = 1'b0;
            exp_done_now = 1'b0;
            stall_prev   = 1'b0;
            rst_prev     = 1'b1;
        end else begin
            check("msg_done", msg_done, exp_done_now);
            if (stall_prev && !rst_prev) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, prev_data);
                check("hold_last", bus.out_last, prev_last);
            end
            if (bus.out_valid && !bus.out_ready) check("in_ready_stall", bus.in_ready, 0);
            in_hs_prev = bus.in_valid && bus.in_ready;
            if (in_hs_prev) in_acc++;
            exp_done_now    = start_zero_flag;
            start_zero_flag = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back(bus.out_data);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL extra_word: got %0h expected no word", bus.out_data);
                end else begin
                    e_word = exp_q.pop_front();
                    e_last = exp_last_q.pop_front();
                    check("out_data", bus.out_data, e_word);
                    check("out_last", bus.out_last, e_last);
                    if (e_last) exp_done_now = 1'b1;
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            rst_prev   = 1'b0;
        end
    end

    function automatic int pad_count(input int len);
        int p;
        p = BW - (len % BW);
`ifndef AES_PAD_FULL_BLOCK_EN
        if (p == BW) p = 0;
`endif
        return p;
    endfunction

    task automatic load_msg(input int len, input bit fixed_data);
        int          padn;
        logic [31:0] d;
        padn = pad_count(len);
        got_q.delete();
        in_acc = 0;
        for (int i = 0; i < len; i++) begin
            d = fixed_data ? 32'((i + 1) * 32'h11) : 32'($urandom);
            src_q.push_back(d);
            exp_q.push_back(d);
            exp_last_q.push_back(padn == 0 && i == len - 1);
        end
        for (int i = 0; i < padn; i++) begin
            exp_q.push_back(32'(padn));
            exp_last_q.push_back(i == padn - 1);
        end
    endtask

    task automatic pulse_start(input int len);
        @(posedge clk);
        #2;
        msg_start     = 1'b1;
        msg_words_out = WCS'(len);
        if (len == 0 && pad_count(0) == 0) start_zero_flag = 1'b1;
        @(posedge clk);
        #2;
        msg_start     = 1'b0;
        msg_words_out = WCS'($urandom);
    endtask

    task automatic run_msg(input int len, input int vpct, input int rpct, input bit inject, input bit fixed_data);
        int cyc;
        bit seen;
        load_msg(len, fixed_data);
        valid_pct = vpct;
        ready_pct = rpct;
        pulse_start(len);
        if (inject) begin
            repeat (2) @(posedge clk);
            #2;
            if (busy) begin
                msg_start     = 1'b1;
                msg_words_out = WCS'(len + 7);
                @(posedge clk);
                #2;
                msg_start = 1'b0;
            end
        end
        cyc  = 0;
        seen = (msg_done === 1'b1);
        while (!seen && cyc < 2000) begin
            @(negedge clk);
            #1;
            seen = (msg_done === 1'b1);
            cyc++;
        end
        if (!seen) begin
            n_checks++;
            n_fails++;
            $display("FAIL msg_done_timeout: got no msg_done expected one within 2000 cycles (len %0d)", len);
        end
        check("words_in_adder", msg_words_in_adder, len);
        check("in_accepted", in_acc, len);
        check("model_drained", exp_q.size(), 0);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        int cyc;
        logic [31:0] lit5[8];
        lit5 = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h3, 32'h3, 32'h3};

        rst = 1'b1;
        msg_start = 1'b0;
        msg_words_out = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_words", msg_words_in_adder, 0);
        check("rst_busy", busy, 0);
        check("rst_msg_done", msg_done, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        drv_en = 1'b1;

        run_msg(5, 100, 100, 1'b0, 1'b1);
        check("len5_count", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) check("len5_word", got_q[i], lit5[i]);

        run_msg(8, 100, 100, 1'b0, 1'b1);
`ifdef AES_PAD_FULL_BLOCK_EN
        check("len8_count", got_q.size(), 12);
        if (got_q.size() == 12) check("len8_pad", got_q[11], 4);
`else
        check("len8_count", got_q.size(), 8);
        if (got_q.size() == 8) check("len8_tail", got_q[7], 32'h88);
`endif

        run_msg(0, 100, 100, 1'b0, 1'b1);
`ifdef AES_PAD_FULL_BLOCK_EN
        check("len0_count", got_q.size(), 4);
        for (int i = 0; i < got_q.size(); i++) check("len0_pad", got_q[i], 4);
`else
        check("len0_count", got_q.size(), 0);
`endif

        pat_idx = 0;
        ready_pat_en = 1'b1;
        run_msg(3, 100, 100, 1'b0, 1'b1);
        ready_pat_en = 1'b0;
        check("len3_count", got_q.size(), 4);
        if (got_q.size() == 4) check("len3_pad", got_q[3], 1);

        run_msg(6, 100, 40, 1'b1, 1'b0);

        load_msg(6, 1'b1);
        valid_pct = 100;
        ready_pct = 100;
        pulse_start(6);
        cyc = 0;
        while (in_acc < 2 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("pre_reset_words", (in_acc >= 2), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        drv_en = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        src_q.delete();
        exp_q.delete();
        exp_last_q.delete();
        start_zero_flag = 1'b0;
        exp_done_now = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_out_data", bus.out_data, 0);
        check("abort_out_last", bus.out_last, 0);
        check("abort_words", msg_words_in_adder, 0);
        check("abort_busy", busy, 0);
        check("abort_msg_done", msg_done, 0);
        #1;
        rst = 1'b0;
        drv_en = 1'b1;
        repeat (3) @(posedge clk);

        run_msg(1, 100, 100, 1'b0, 1'b1);
        check("len1_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("len1_data", got_q[0], 32'h11);
            for (int i = 1; i < 4; i++) check("len1_pad", got_q[i], 3);
        end

        for (int t = 0; t < 16; t++) begin
            run_msg($urandom_range(0, 13), $urandom_range(40, 100), $urandom_range(30, 100),
                    1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/aes_padding_adder.md
# aes_padding_adder

Streaming padding stage directly downstream of the register controller's message interface. On `msg_start` it latches the message length `msg_words_out`, forwards exactly that many 32-bit words from the input stream to the AES block feeder, then appends word-granular PKCS#7-style pad words up to the next AES block boundary. It reports its accepted-word count back to the register controller on `msg_words_in_adder`.

## Interface
Parameters:
- `WORD_SIZE`, 32, data word width in bits.
- `BLOCK_WORDS`, 4, words per AES block; must be a power of two and at least 2.
- `WORD_COUNTER_SIZE`, 16, width of the message-length and word counters.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `msg_start`  in  1  one-cycle pulse that begins a message; sampled only in IDLE.
- `msg_words_out`  in  WORD_COUNTER_SIZE  message length in words; sampled with `msg_start`.
- `in_data`  in  WORD_SIZE  upstream word.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  upstream word accepted when `in_valid && in_ready`.
- `out_data`  out  WORD_SIZE  registered output word.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts the word when `out_valid && out_ready`.
- `out_last`  out  1  marks the final word (data or pad) of the padded message.
- `msg_words_in_adder`  out  WORD_COUNTER_SIZE  count of data words accepted in the current or last message.
- `busy`  out  1  high in any state other than IDLE.
- `msg_done`  out  1  one-cycle pulse when the message completes.

## Operation
- States: IDLE, PASS, PAD.
- IDLE:
  - On `msg_start`, latch `len = msg_words_out` and `pad = BLOCK_WORDS - (len mod BLOCK_WORDS)`. The mod is computed from the low log2(BLOCK_WORDS) bits.
  - Clear `msg_words_in_adder`.
  - Go to PASS if `len > 0`. Otherwise go to PAD if `pad > 0`. Otherwise pulse `msg_done` and stay in IDLE.
- PASS:
  - `in_ready = !out_valid || out_ready`.
  - Each input handshake loads the word into the output register and increments `msg_words_in_adder`.
  - On the handshake of word number `len`, go to PAD, or to IDLE if `pad == 0`. In the IDLE case, `out_last` is set on that word.
- PAD:
  - `in_ready = 0`.
  - When the output slot is free, load pad word `{zeros, pad}` (pad count, zero-extended) and decrement the remaining-pad counter.
  - `out_last` is set on the final pad word.
  - Once the final pad word has been loaded, return to IDLE.
- `msg_done` pulses in the cycle after the `out_last` word completes its output handshake, or immediately in the zero-length case described above.
- A `msg_start` arriving while `busy` is ignored. A new `msg_start` is honoured only once the output register holds no `out_last` word.
- Counter arithmetic is unsigned modulo 2^WORD_COUNTER_SIZE. `len` reaching 2^WORD_COUNTER_SIZE-1 is legal.

## Timing
- Reset values: `in_ready=0`, `out_valid=0`, `out_data=0`, `out_last=0`, `msg_words_in_adder=0`, `busy=0`, `msg_done=0`, state IDLE.
- `msg_start` in cycle 0 puts the block in PASS in cycle 1, so `in_ready` can be high from cycle 1.
- Latency is 1 cycle: a word accepted in cycle n is on `out_data` in cycle n+1.
- Throughput is 1 word per cycle while `out_ready` stays high. Pad words follow the last data word with no bubble.
- Backpressure: `out_data`, `out_valid` and `out_last` hold stable while `out_valid && !out_ready`. `in_ready` is deasserted in the same cycle.
- Simultaneous output handshake and new load in one cycle is legal and required for full rate.
- Reset mid-message aborts immediately: all outputs return to reset values on the next edge, no `msg_done` is generated, and remaining pad words are dropped.

## Configuration
- `AES_PAD_FULL_BLOCK_EN` defined: when `len mod BLOCK_WORDS == 0`, `pad = BLOCK_WORDS`. A full pad block is appended, including for `len = 0`.
- Not defined: when `len mod BLOCK_WORDS == 0`, `pad = 0`.
  - For `len > 0`, the last data word carries `out_last`.
  - For `len = 0`, the block pulses `msg_done` the cycle after `msg_start`, outputs nothing and stays in IDLE.

## Test plan
- `len=5`, BLOCK_WORDS=4, continuous valid/ready, data 0x11..0x55 -> output is 0x11, 0x22, 0x33, 0x44, 0x55, then 3, 3, 3. `out_last` is set on the 8th word, `msg_words_in_adder=5`, and `msg_done` pulses 1 cycle after the last handshake.
- `len=8`:
  - With the macro: 8 data words, then four words of value 4.
  - Without the macro: 8 data words with `out_last` on the 8th and no pad.
- `len=0`:
  - With the macro: four words of value 4.
  - Without the macro: no `out_valid`; `msg_done` is high in cycle 1.
- `len=3` with `out_ready` toggling 1,0,0,1 -> `out_data` is held during stalls, `in_ready` is low on stalled cycles, and output is words 1..3 then 1 with `out_last`.
- `msg_start` asserted in PASS with a different `msg_words_out` -> ignored; the original length completes unchanged.
- `rst` asserted after 2 of 6 words -> the next cycle shows all outputs at reset values and no `msg_done`. A new `msg_start` with `len=1` then produces a data word followed by three words of value 3.
